// File: rtl/line_window_buffer.sv
// KH-row sliding-window line buffer: stores input rows in a ring and streams padded windows one group per beat.
// Optional LINE_WIN_SOF_EN adds in_sof, which aborts the current frame and restarts on the flagged row.
module line_window_buffer #(
    parameter int DATA_BITS = 8,
    parameter int D         = 1,
    parameter int W         = 24,
    parameter int H         = 24,
    parameter int K         = 6,
    parameter int KH        = 3,
    parameter int P         = 1
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [K*D*W*DATA_BITS-1:0]          in_data,
    input  logic                                in_valid,
`ifdef LINE_WIN_SOF_EN
    input  logic                                in_sof,
`endif
    output logic                                in_ready,
    output logic [KH*D*(W+2*P)*DATA_BITS-1:0]   out_window,
    output logic [$clog2(K):0]                  out_group,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_last
);
    localparam int GRP_BITS  = D*W*DATA_BITS;
    localparam int ROW_BITS  = K*GRP_BITS;
    localparam int PAD_BITS  = P*D*DATA_BITS;
    localparam int PROW_BITS = GRP_BITS + 2*PAD_BITS;
    localparam int WIN_BITS  = KH*PROW_BITS;
    localparam int H_OUT     = H + 2*P - KH + 1;
    localparam int CW        = $clog2(H+1);
    localparam int RW        = $clog2(H_OUT+1);
    localparam int SW        = $clog2(KH);
    localparam int GW        = $clog2(K) + 1;
    localparam int BASE0     = (KH - P) % KH;

    // FILL accepts rows, EMIT streams the K groups of a window, DONE clears for the next frame
    typedef enum logic [1:0] {S_FILL, S_EMIT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ROW_BITS-1:0]   ring_q [KH];
    logic [CW-1:0]         in_cnt_q, in_cnt_d;
    logic [RW-1:0]         out_row_q, out_row_d, ld_row;
    logic [SW-1:0]         rd_base_q, rd_base_d, ld_base;
    logic [SW-1:0]         wr_slot_q, wr_slot_d, wr_idx;
    logic [GW-1:0]         grp_q, grp_d, ld_grp;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [WIN_BITS-1:0]   out_window_q, win_build;
    logic                  wr_en, ring_clr, load_win, accept, sof_hit;

    function automatic logic win_ready(input int r, input int cnt);
        return (r + KH <= P + cnt) || (cnt == H);
    endfunction

    function automatic logic is_last(input int r, input int g);
        return (r == H_OUT-1) && (g == K-1);
    endfunction

    function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
        return (int'(s) == KH-1) ? '0 : s + 1'b1;
    endfunction

    // rd_base is the ring slot of input row (r-P); rows outside the frame read as zero
    always_comb begin
        win_build = '0;
        for (int i = 0; i < KH; i++) begin
            int q;
            int slot;
            q    = int'(ld_row) + i;
            slot = int'(ld_base) + i;
            if (slot >= KH) slot = slot - KH;
            if (q >= P && q < P + H)
                win_build[i*PROW_BITS + PAD_BITS +: GRP_BITS] =
                    ring_q[slot[SW-1:0]][int'(ld_grp)*GRP_BITS +: GRP_BITS];
        end
    end

    assign in_ready = (state_q == S_FILL) && (int'(in_cnt_q) < H) &&
                      !win_ready(int'(out_row_q), int'(in_cnt_q));
    assign accept   = in_valid && in_ready;

`ifdef LINE_WIN_SOF_EN
    assign sof_hit = accept && in_sof;
`else
    assign sof_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        out_row_d   = out_row_q;
        grp_d       = grp_q;
        rd_base_d   = rd_base_q;
        wr_slot_d   = wr_slot_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        ld_row      = out_row_q;
        ld_base     = rd_base_q;
        ld_grp      = grp_q;
        load_win    = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = wr_slot_q;
        ring_clr    = 1'b0;
        case (state_q)
            S_FILL: begin
                if (win_ready(int'(out_row_q), int'(in_cnt_q))) begin
                    state_d     = S_EMIT;
                    out_valid_d = 1'b1;
                    grp_d       = '0;
                    ld_grp      = '0;
                    load_win    = 1'b1;
                    out_last_d  = is_last(int'(out_row_q), 0);
                end else if (accept) begin
                    wr_en     = 1'b1;
                    in_cnt_d  = in_cnt_q + 1'b1;
                    wr_slot_d = slot_inc(wr_slot_q);
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (int'(grp_q) != K-1) begin
                        grp_d      = grp_q + 1'b1;
                        ld_grp     = grp_d;
                        load_win   = 1'b1;
                        out_last_d = is_last(int'(out_row_q), int'(grp_q) + 1);
                    end else if (int'(out_row_q) == H_OUT-1) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_row_d = out_row_q + 1'b1;
                        rd_base_d = slot_inc(rd_base_q);
                        grp_d     = '0;
                        if (win_ready(int'(out_row_q) + 1, int'(in_cnt_q))) begin
                            load_win   = 1'b1;
                            ld_row     = out_row_d;
                            ld_base    = rd_base_d;
                            ld_grp     = '0;
                            out_last_d = is_last(int'(out_row_q) + 1, 0);
                        end else begin
                            state_d     = S_FILL;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                        end
                    end
                end
            end
            S_DONE: begin
                ring_clr    = 1'b1;
                in_cnt_d    = '0;
                out_row_d   = '0;
                grp_d       = '0;
                rd_base_d   = SW'(BASE0);
                wr_slot_d   = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                state_d     = S_FILL;
            end
            default: state_d = S_FILL;
        endcase
        if (sof_hit) begin
            ring_clr    = 1'b1;
            wr_en       = 1'b1;
            wr_idx      = '0;
            in_cnt_d    = CW'(1);
            out_row_d   = '0;
            grp_d       = '0;
            rd_base_d   = SW'(BASE0);
            wr_slot_d   = SW'(1);
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            load_win    = 1'b0;
            state_d     = S_FILL;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_FILL;
            in_cnt_q     <= '0;
            out_row_q    <= '0;
            grp_q        <= '0;
            rd_base_q    <= SW'(BASE0);
            wr_slot_q    <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_window_q <= '0;
            for (int i = 0; i < KH; i++) ring_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_row_q   <= out_row_d;
            grp_q       <= grp_d;
            rd_base_q   <= rd_base_d;
            wr_slot_q   <= wr_slot_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            if (load_win) out_window_q <= win_build;
            if (ring_clr) begin
                for (int i = 0; i < KH; i++) ring_q[i] <= '0;
            end
            if (wr_en) ring_q[wr_idx] <= in_data;
        end
    end

    assign out_window = out_window_q;
    assign out_group  = grp_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: random and directed frames checked against a pixel-level window model.
module tb_line_window_buffer;
    localparam int DB       = 8;
    localparam int D        = 1;
    localparam int W        = 4;
    localparam int H        = 4;
    localparam int K        = 2;
    localparam int KH       = 3;
    localparam int P        = 1;
    localparam int H_OUT    = H + 2*P - KH + 1;
    localparam int ROW_BITS = K*D*W*DB;
    localparam int WIN_BITS = KH*D*(W+2*P)*DB;
    localparam int GW       = $clog2(K) + 1;
    localparam int BEATS    = H_OUT*K;
    localparam logic [WIN_BITS-1:0] BEAT0 = 144'h000202020200_000101010100_000000000000;
    localparam logic [WIN_BITS-1:0] BEAT1 = 144'h001212121200_001111111100_000000000000;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic [ROW_BITS-1:0] in_data = '0;
    logic                in_valid = 1'b0;
`ifdef LINE_WIN_SOF_EN
    logic                in_sof = 1'b0;
`endif
    logic                in_ready;
    logic [WIN_BITS-1:0] out_window;
    logic [GW-1:0]       out_group;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                out_last;

    int total = 0;
    int bad   = 0;
    int beats = 0;
    logic [ROW_BITS-1:0] fr [2][H];

    always #5 clk = ~clk;

    line_window_buffer #(.DATA_BITS(DB), .D(D), .W(W), .H(H), .K(K), .KH(KH), .P(P)) dut (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
`ifdef LINE_WIN_SOF_EN
        .in_sof(in_sof),
`endif
        .in_ready(in_ready), .out_window(out_window), .out_group(out_group),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    // window row i of output row r is padded row r+i; padded row q holds input row q-P shifted by P pixels
    function automatic logic [WIN_BITS-1:0] exp_window(input int f, input int r, input int g);
        logic [WIN_BITS-1:0] w;
        logic [ROW_BITS-1:0] row;
        w = '0;
        for (int i = 0; i < KH; i++) begin
            int q;
            q = r + i;
            if (q >= P && q < P + H) begin
                row = fr[f][q-P];
                for (int x = 0; x < W; x++)
                    w[(i*(W+2*P) + x + P)*DB +: DB] = row[(g*W + x)*DB +: DB];
            end
        end
        return w;
    endfunction

    task automatic fill_frame(input int f, input int pat);
        for (int n = 0; n < H; n++)
            for (int g = 0; g < K; g++)
                for (int x = 0; x < W; x++)
                    fr[f][n][(g*W + x)*DB +: DB] = (pat == 0) ? 8'(n + 1 + 16*g) : 8'($urandom_range(0, 255));
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef LINE_WIN_SOF_EN
        in_sof    = 1'b0;
`endif
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive_partial(input int n);
        int idx = 0;
        int cyc = 0;
        bit acc = 0;
        while (idx < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (acc) idx++;
            acc = 0;
            if (idx < n) begin
                in_valid = 1'b1;
                in_data  = fr[0][idx];
                acc      = in_ready;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        total++;
        if (idx < n) begin bad++; $display("FAIL partial_rows: accepted=%0d want=%0d", idx, n); end
    endtask

    // pat: 0 directed, 1 random, 2 random with frame 1 a copy of frame 0
    // ready_mode: 0 always ready, 1 random ready, 2 one 5-cycle stall mid-frame
    task automatic run_frame(input int nframes, input int pat, input int ready_mode,
                             input bit gaps, input bit sof_first);
        int nrows  = nframes*H;
        int nbeats = nframes*BEATS;
        fill_frame(0, pat);
        if (pat == 2) fr[1] = fr[0];
        else if (nframes > 1) fill_frame(1, pat);
        beats = 0;
        fork
            begin : drv
                int idx = 0;
                int cyc = 0;
                bit acc = 0;
                while (idx < nrows && cyc < 4000) begin
                    @(negedge clk);
                    cyc++;
                    if (acc) idx++;
                    acc = 0;
                    if (idx < nrows) begin
                        in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                        in_data  = fr[idx/H][idx%H];
`ifdef LINE_WIN_SOF_EN
                        in_sof   = sof_first && (idx == 0);
`endif
                        acc = in_valid && in_ready;
                        if (acc && idx > 0 && idx % H == 0) begin
                            total++;
                            if (beats < (idx/H)*BEATS) begin
                                bad++;
                                $display("FAIL frame_hold: next frame row accepted after %0d beats, want %0d", beats, (idx/H)*BEATS);
                            end
                        end
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                in_valid = 1'b0;
`ifdef LINE_WIN_SOF_EN
                in_sof   = 1'b0;
`endif
                if (idx < nrows) begin
                    total++; bad++;
                    $display("FAIL drive_timeout: rows accepted=%0d want=%0d", idx, nrows);
                end
            end
            begin : mon
                int cyc = 0;
                int stall_cnt = 0;
                int f, r, g;
                while (beats < nbeats && cyc < 4000) begin
                    @(negedge clk);
                    cyc++;
                    case (ready_mode)
                        0: out_ready = 1'b1;
                        1: out_ready = ($urandom_range(0, 2) != 0);
                        default: begin
                            if (beats == 3 && stall_cnt < 5) begin
                                out_ready = 1'b0;
                                stall_cnt++;
                                total++;
                                if (out_valid !== 1'b1) begin
                                    bad++;
                                    $display("FAIL stall_valid: out_valid=%b want 1", out_valid);
                                end
                            end else begin
                                out_ready = 1'b1;
                            end
                        end
                    endcase
                    if (out_valid === 1'b1) begin
                        f = beats / BEATS;
                        r = (beats % BEATS) / K;
                        g = beats % K;
                        total++;
                        if (out_window !== exp_window(f, r, g)) begin
                            bad++;
                            $display("FAIL window f%0d r%0d g%0d: got %h want %h", f, r, g, out_window, exp_window(f, r, g));
                        end
                        total++;
                        if (out_group !== GW'(g)) begin
                            bad++;
                            $display("FAIL group f%0d r%0d: got %0d want %0d", f, r, out_group, g);
                        end
                        total++;
                        if (out_last !== ((r == H_OUT-1) && (g == K-1))) begin
                            bad++;
                            $display("FAIL last f%0d r%0d g%0d: got %b", f, r, g, out_last);
                        end
                        if (out_ready) beats++;
                    end
                end
                total++;
                if (beats < nbeats) begin
                    bad++;
                    $display("FAIL beat_timeout: beats=%0d want=%0d", beats, nbeats);
                end else begin
                    @(negedge clk);
                    total++;
                    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL done_cycle: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
                    end
                    @(negedge clk);
                    total++;
                    if (in_ready !== 1'b1) begin
                        bad++;
                        $display("FAIL ready_after_done: in_ready=%b want 1", in_ready);
                    end
                end
                out_ready = 1'b0;
            end
        join
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_last !== 1'b0)  begin bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        total++; if (out_group !== '0)   begin bad++; $display("FAIL reset_out_group: got %0d want 0", out_group); end
        total++; if (out_window !== '0)  begin bad++; $display("FAIL reset_out_window: got %h want 0", out_window); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_window();
        do_reset();
        fill_frame(0, 0);
        in_valid = 1'b1;
        in_data  = fr[0][0];
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_data = fr[0][1];
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL early_valid: got %b want 0", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", out_valid); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL emit_ready: got %b want 0", in_ready); end
        total++; if (out_group !== '0)   begin bad++; $display("FAIL beat0_group: got %0d want 0", out_group); end
        total++; if (out_window !== BEAT0) begin bad++; $display("FAIL beat0_window: got %h want %h", out_window, BEAT0); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (out_group !== GW'(1)) begin bad++; $display("FAIL beat1_group: got %0d want 1", out_group); end
        total++; if (out_window !== BEAT1) begin bad++; $display("FAIL beat1_window: got %h want %h", out_window, BEAT1); end
    endtask

    task automatic test_full_frame();
        do_reset();
        run_frame(1, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) run_frame(1, 1, 1, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        run_frame(1, 1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame(2, 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        fill_frame(0, 1);
        out_ready = 1'b1;
        drive_partial(3);
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
        #2 resetn = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL async_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_out_valid: got %b want 0", out_valid); end
        total++; if (out_last !== 1'b0)  begin bad++; $display("FAIL async_out_last: got %b want 0", out_last); end
        total++; if (out_window !== '0)  begin bad++; $display("FAIL async_out_window: got %h want 0", out_window); end
        out_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_frame(1, 0, 0, 1'b0, 1'b0);
    endtask

`ifdef LINE_WIN_SOF_EN
    task automatic test_sof();
        int cyc = 0;
        fill_frame(0, 1);
        out_ready = 1'b1;
        drive_partial(2);
        while (!(out_valid === 1'b0 && in_ready === 1'b1) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        run_frame(1, 1, 0, 1'b0, 1'b1);
        run_frame(1, 0, 1, 1'b0, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_first_window();
        test_full_frame();
        test_random();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef LINE_WIN_SOF_EN
        test_sof();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
